// File: rtl/delay_period_monitor.sv
// ---------------------------------------------------------------------------
// delay_period_monitor
//
// Receive-side checker for the periodic strobe 'sig' from the DELAY pulse
// generator. It measures the interval between strobes and asserts 'locked'
// after LOCK_CNT consecutive good intervals. It reports early strobes and
// missing (late) strobes. After lock is lost it holds a sticky fault until
// 'clr' is asserted.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   en           in   monitor enable; low holds the monitor in IDLE
//   clr          in   synchronous clear of the fault state (returns to IDLE)
//   sig          in   1-cycle strobe under test
//   locked       out  high while in LOCKED
//   fault        out  high while in FAULT
//   err_early    out  1-cycle pulse: strobe arrived before PERIOD-TOL
//   err_late     out  1-cycle pulse: no strobe by PERIOD+TOL
//   last_period  out  interval measured at the most recent strobe
//   err_cnt      out  early+late errors since reset, saturating at 255
// ---------------------------------------------------------------------------
module delay_period_monitor #(
    parameter int PERIOD   = 15001,
    parameter int TOL      = 0,
    parameter int LOCK_CNT = 4,
    parameter int CBITS    = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             sig,
    output logic             locked,
    output logic             fault,
    output logic             err_early,
    output logic             err_late,
    output logic [CBITS-1:0] last_period,
    output logic [7:0]       err_cnt
);

    localparam int GBITS = $clog2(LOCK_CNT + 1);

    // Interval thresholds are held one bit wider than the counter so that
    // ival = cnt+1 never wraps.
    localparam logic [CBITS:0]   EARLY_LIM = (CBITS+1)'(PERIOD - TOL);
    localparam logic [CBITS:0]   LATE_LIM  = (CBITS+1)'(PERIOD + TOL + 1);
    localparam logic [CBITS-1:0] CNT_MAX   = '1;
    localparam logic [GBITS-1:0] LOCK_TGT  = GBITS'(LOCK_CNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACQ,
        S_LOCKED,
        S_FAULT
    } state_t;

    state_t           state_q, state_d;
    logic [CBITS-1:0] cnt_q, cnt_d;
    logic [GBITS-1:0] good_q, good_d;
    logic [CBITS-1:0] last_period_q, last_period_d;
    logic             err_early_q, err_early_d;
    logic             err_late_q, err_late_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [CBITS:0]   ival;
    logic             is_early;
    logic             is_timeout;
    logic [GBITS-1:0] good_inc;

    assign ival       = {1'b0, cnt_q} + (CBITS+1)'(1);
    assign is_early   = (ival < EARLY_LIM);
    // A strobe landing on the threshold cycle wins, so timeout needs sig=0.
    // The equality (not >=) makes it fire once per gap while cnt runs on.
    assign is_timeout = !sig && (ival == LATE_LIM);
    assign good_inc   = good_q + GBITS'(1);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        good_d        = good_q;
        last_period_d = last_period_q;
        err_early_d   = 1'b0;
        err_late_d    = 1'b0;
        err_cnt_d     = err_cnt_q;

        if (!en || clr) begin
            // Disable and clear both drop to IDLE and swallow any strobe.
            state_d = S_IDLE;
            cnt_d   = '0;
            good_d  = '0;
        end else begin
            if (sig)
                cnt_d = '0;
            else if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + CBITS'(1);

            if (state_q == S_IDLE) begin
                // First strobe only establishes phase; no interval check.
                if (sig) begin
                    state_d = S_ACQ;
                    good_d  = '0;
                end
            end else if (sig) begin
                // A saturated counter reports the largest representable value.
                last_period_d = ival[CBITS] ? CNT_MAX : ival[CBITS-1:0];
                if (is_early) begin
                    err_early_d = 1'b1;
                    if (state_q == S_ACQ)
                        good_d = '0;
                    else if (state_q == S_LOCKED)
                        state_d = S_FAULT;
                end else if (state_q == S_ACQ) begin
                    good_d = good_inc;
                    if (good_inc == LOCK_TGT)
                        state_d = S_LOCKED;
                end
            end else if (is_timeout) begin
                err_late_d = 1'b1;
                if (state_q == S_ACQ) begin
                    state_d = S_IDLE;
                    good_d  = '0;
                end else if (state_q == S_LOCKED) begin
                    state_d = S_FAULT;
                end
            end
        end

        if ((err_early_d || err_late_d) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            good_q        <= '0;
            last_period_q <= '0;
            err_early_q   <= 1'b0;
            err_late_q    <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            good_q        <= good_d;
            last_period_q <= last_period_d;
            err_early_q   <= err_early_d;
            err_late_q    <= err_late_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign locked      = (state_q == S_LOCKED);
    assign fault       = (state_q == S_FAULT);
    assign err_early   = err_early_q;
    assign err_late    = err_late_q;
    assign last_period = last_period_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_delay_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_delay_period_monitor
//
// Directed scenarios followed by a randomized strobe phase. A reference model
// tracks the edge index of the last counter restart and derives each interval
// as a plain difference of edge numbers; all DUT outputs are compared with it
// on every falling edge, plus named checks at the scenario points of interest.
// ---------------------------------------------------------------------------
module tb_delay_period_monitor;

    localparam int PERIOD   = 10;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int CBITS    = 5;
    localparam int CMAX     = (1 << CBITS) - 1;

    localparam int M_IDLE   = 0;
    localparam int M_ACQ    = 1;
    localparam int M_LOCKED = 2;
    localparam int M_FAULT  = 3;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             clr;
    logic             sig;
    logic             locked;
    logic             fault;
    logic             err_early;
    logic             err_late;
    logic [CBITS-1:0] last_period;
    logic [7:0]       err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int edge_n = 0;
    int m_mode;
    int m_good;
    int m_ref;      // edge index at which the interval counter last restarted
    int m_last;
    int m_errcnt;
    bit m_early;
    bit m_late;

    delay_period_monitor #(
        .PERIOD   (PERIOD),
        .TOL      (TOL),
        .LOCK_CNT (LOCK_CNT),
        .CBITS    (CBITS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .sig         (sig),
        .locked      (locked),
        .fault       (fault),
        .err_early   (err_early),
        .err_late    (err_late),
        .last_period (last_period),
        .err_cnt     (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_good   = 0;
        m_ref    = edge_n;
        m_last   = 0;
        m_errcnt = 0;
        m_early  = 0;
        m_late   = 0;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    function automatic void model_step();
        int ival;
        edge_n++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_early = 0;
        m_late  = 0;
        if (!en || clr) begin
            m_mode = M_IDLE;
            m_good = 0;
            m_ref  = edge_n;
        end else begin
            ival = edge_n - m_ref;
            if (m_mode == M_IDLE) begin
                if (sig) begin
                    m_mode = M_ACQ;
                    m_good = 0;
                end
            end else if (sig) begin
                m_last = (ival > CMAX) ? CMAX : ival;
                if (ival < PERIOD - TOL) begin
                    m_early = 1;
                    if (m_mode == M_ACQ) m_good = 0;
                    else if (m_mode == M_LOCKED) m_mode = M_FAULT;
                end else if (m_mode == M_ACQ) begin
                    m_good++;
                    if (m_good == LOCK_CNT) m_mode = M_LOCKED;
                end
            end else if (ival == PERIOD + TOL + 1) begin
                m_late = 1;
                if (m_mode == M_ACQ) begin
                    m_mode = M_IDLE;
                    m_good = 0;
                end else if (m_mode == M_LOCKED) begin
                    m_mode = M_FAULT;
                end
            end
            if (sig) m_ref = edge_n;
        end
        if ((m_early || m_late) && m_errcnt < 255) m_errcnt++;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic check_cycle();
        logic [CBITS+11:0] obs;
        logic [CBITS+11:0] exp;
        obs = {locked, fault, err_early, err_late, last_period, err_cnt};
        exp = {m_mode == M_LOCKED, m_mode == M_FAULT, m_early, m_late,
               CBITS'(m_last), 8'(m_errcnt)};
        check("cycle {locked,fault,early,late,last_period,err_cnt}", 32'(obs), 32'(exp));
    endtask

    // One clock: drive sig, let the edge happen, compare on the falling edge.
    task automatic step(input logic s);
        sig = s;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    // gap-1 idle cycles followed by a strobe, giving an interval of 'gap'.
    task automatic strobe(input int gap);
        for (int i = 1; i < gap; i++) step(1'b0);
        step(1'b1);
    endtask

    initial begin
        int r;
        int g;
        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        sig   = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check("reset_outputs", {locked, fault, err_early, err_late, last_period, err_cnt}, 0);
        step(1'b0);
        step(1'b1);
        rst_n = 1'b1;
        en    = 1'b1;

        // Regular strobes every PERIOD: lock after LOCK_CNT good intervals
        strobe(3);
        strobe(10);
        strobe(10);
        check("not_locked_after_2_good", locked, 0);
        strobe(10);
        check("locked_after_3_good", locked, 1);
        check("no_errors_while_locking", err_cnt, 0);

        // Early strobe while locked
        strobe(8);
        check("early_pulse", err_early, 1);
        check("early_fault", fault, 1);
        check("early_unlocked", locked, 0);
        check("early_last_period", last_period, 8);
        check("early_err_cnt", err_cnt, 1);
        step(1'b0);
        check("early_pulse_1_cycle", err_early, 0);

        // clr with a coincident strobe: strobe ignored, back to IDLE
        clr = 1'b1;
        step(1'b1);
        clr = 1'b0;
        check("clr_fault_cleared", fault, 0);
        check("clr_sig_ignored_err_cnt", err_cnt, 1);
        check("clr_last_period_held", last_period, 8);
        strobe(5);
        strobe(10);
        strobe(10);
        strobe(10);
        check("relock_after_clr", locked, 1);
        check("relock_err_cnt", err_cnt, 1);

        // Missing strobe while locked
        for (int i = 0; i < 11; i++) step(1'b0);
        check("late_not_yet", err_late, 0);
        step(1'b0);
        check("late_pulse", err_late, 1);
        check("late_fault", fault, 1);
        check("late_err_cnt", err_cnt, 2);
        step(1'b0);
        check("late_pulse_1_cycle", err_late, 0);
        for (int i = 0; i < 25; i++) step(1'b0);
        check("late_once_per_gap", err_cnt, 2);
        strobe(4);
        check("fault_sticky", fault, 1);

        // Early interval during acquisition re-syncs without leaving ACQ
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        strobe(4);
        strobe(10);
        strobe(7);
        check("acq_early_pulse", err_early, 1);
        check("acq_early_no_fault", fault, 0);
        check("acq_early_last_period", last_period, 7);
        check("acq_early_err_cnt", err_cnt, 3);
        strobe(10);
        strobe(10);
        check("acq_good_reset", locked, 0);
        strobe(10);
        check("acq_relock", locked, 1);

        // Strobe exactly on the timeout cycle counts as good
        strobe(12);
        check("threshold_strobe_good", locked, 1);
        check("threshold_last_period", last_period, 12);

        // Randomized strobe phase, checked every cycle against the model
        for (int k = 0; k < 90; k++) begin
            r = $urandom_range(0, 99);
            if (r < 4) begin
                clr = 1'b1;
                step(1'($urandom_range(0, 1)));
                clr = 1'b0;
            end else if (r < 8) begin
                en = 1'b0;
                g  = $urandom_range(1, 15);
                for (int i = 0; i < g; i++) step(1'($urandom_range(0, 3) == 0));
                en = 1'b1;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 70)      g = $urandom_range(9, 11);
                else if (r < 85) g = $urandom_range(2, 8);
                else             g = $urandom_range(12, 40);
                strobe(g);
            end
        end

        // Lock, then assert reset asynchronously between edges
        clr = 1'b1;
        step(1'b0);
        clr = 1'b0;
        strobe(4);
        strobe(10);
        strobe(10);
        strobe(10);
        check("locked_before_reset", locked, 1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_outputs", {locked, fault, err_early, err_late, last_period, err_cnt}, 0);
        step(1'b0);
        step(1'b1);

        // Disabled after release: strobes are ignored
        en    = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'(i % 5 == 4));
        check("disabled_not_locked", locked, 0);
        check("disabled_no_fault", fault, 0);
        check("disabled_err_cnt", err_cnt, 0);
        en = 1'b1;
        strobe(2);
        strobe(10);
        strobe(10);
        strobe(10);
        check("lock_after_enable", locked, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
